rr_bus_arbiter_8: RTL

Round-robin arbiter and sequencer that shares one 16-bit output bus among 8 requesters. It drives the 3-bit select of the 8:1 16-bit word multiplexer and grants one requester at a time for a burst of beats. It releases the grant on the last beat, when the burst limit is reached, or when the owner abandons its request. The block sits between the requesting units and the single downstream consumer of the muxed word.

---
 rtl/arb_defs_pkg.sv | 18 +
 rtl/rr_pick8.sv | 30 +++
 rtl/word_mux8.sv | 36 +++
 rtl/rr_bus_arbiter_8.sv | 100 ++++++++++
 4 files changed

// File: rtl/arb_defs_pkg.sv
// rtl/arb_defs_pkg.sv - shared constants and types for the round-robin bus arbiter
package arb_defs_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int W     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One-hot decode of a requester index
  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational rotating-priority encoder over eight requests
module rr_pick8
  import arb_defs_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] win,
  output logic       any
);

  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  first;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[7:0];
  assign any = |req;

  // Lowest set bit of the rotated vector is the winner relative to ptr
  always_comb begin
    first = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = 3'(i);
    end
  end

  // Un-rotate back to an absolute requester index (wraps mod 8)
  assign win = ptr + first;

endmodule

// File: rtl/word_mux8.sv
// rtl/word_mux8.sv - 8:1 word multiplexer with per-bit select lines s1/s2/s3
module word_mux8 #(
  parameter int W = 16
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [W-1:0] d4,
  input  logic [W-1:0] d5,
  input  logic [W-1:0] d6,
  input  logic [W-1:0] d7,
  input  logic [W-1:0] s1,
  input  logic [W-1:0] s2,
  input  logic [W-1:0] s3,
  output logic [W-1:0] y
);

  // Each output bit selects independently; s1 is the least significant select
  always_comb begin
    y = '0;
    for (int b = 0; b < W; b++) begin
      case ({s3[b], s2[b], s1[b]})
        3'd0:    y[b] = d0[b];
        3'd1:    y[b] = d1[b];
        3'd2:    y[b] = d2[b];
        3'd3:    y[b] = d3[b];
        3'd4:    y[b] = d4[b];
        3'd5:    y[b] = d5[b];
        3'd6:    y[b] = d6[b];
        default: y[b] = d7[b];
      endcase
    end
  end

endmodule

// File: rtl/rr_bus_arbiter_8.sv
// rtl/rr_bus_arbiter_8.sv - round-robin burst arbiter sharing one word bus among eight requesters
module rr_bus_arbiter_8 #(
  parameter int W         = 16,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     req,
  input  logic [7:0]     last,
  input  logic [8*W-1:0] din,
  output logic [7:0]     gnt,
  output logic [2:0]     sel,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           out_ready
);

  import arb_defs_pkg::*;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] ptr;
  logic [3:0] cnt;
  logic [2:0] win;
  logic       any;
  logic       beat;
  logic       rel;
  logic [W-1:0] mux_y;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  word_mux8 #(.W(W)) u_mux (
    .d0 (din[0*W +: W]),
    .d1 (din[1*W +: W]),
    .d2 (din[2*W +: W]),
    .d3 (din[3*W +: W]),
    .d4 (din[4*W +: W]),
    .d5 (din[5*W +: W]),
    .d6 (din[6*W +: W]),
    .d7 (din[7*W +: W]),
    .s1 ({W{sel[0]}}),
    .s2 ({W{sel[1]}}),
    .s3 ({W{sel[2]}}),
    .y  (mux_y)
  );

  // State register; reset drops any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: release on last beat, burst limit, or owner abandoning its request
  always_comb begin
    beat      = out_valid & out_ready;
    rel       = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: if (any) state_nxt = BUSY;
      BUSY: begin
        rel = ~req[sel] | (beat & (last[sel] | (cnt == 4'(MAX_BURST - 1))));
        if (rel) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: only the owner's presented beat is visible, zero otherwise
  always_comb begin
    out_valid = (state == BUSY) & req[sel];
    out_data  = out_valid ? mux_y : '0;
  end

  // Grant, owner index, rotation pointer and beat counter; sel holds across release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= '0;
      sel <= '0;
      ptr <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (any) begin
        gnt <= onehot8(win);
        sel <= win;
        cnt <= '0;
      end
    end else if (rel) begin
      gnt <= '0;
      ptr <= sel + 3'd1;
    end else if (beat) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule
